// File: rtl/p_sub_arb_pkg.sv
// Shared types for the arbitrated saturating subtractor: data configs and arbiter state.
package p_sub_arb_pkg;

  typedef struct packed {
    int unsigned prec;
    logic        sgn;
  } dconf_t;

  localparam dconf_t DEF_DCONF_INT  = '{prec: 32'd8, sgn: 1'b1};
  localparam dconf_t DEF_DCONF_UINT = '{prec: 32'd8, sgn: 1'b0};

  typedef enum logic {
    StEmpty,
    StFull
  } arb_state_e;

endpackage

// File: rtl/p_sub_arb_if.sv
// Request/response bundle between subtract requesters (master) and the arbiter (slave).
interface p_sub_arb_if #(
  parameter int unsigned REQ     = 4,
  parameter int unsigned I1_PREC = 8,
  parameter int unsigned I2_PREC = 8,
  parameter int unsigned O_PREC  = 8
);
  localparam int unsigned ID_W = $clog2(REQ);

  logic [REQ-1:0]         req_valid;
  logic [REQ-1:0]         req_ready;
  logic [REQ*I1_PREC-1:0] req_in1;
  logic [REQ*I2_PREC-1:0] req_in2;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [O_PREC-1:0]      rsp_out;
  logic                   rsp_ovf;

  modport master (
    output req_valid, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_ovf
  );

  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_ovf
  );

endinterface

// File: rtl/p_int_sub.sv
// Saturating subtract in1 - in2 with independently signed operands and result.
module p_int_sub #(
  parameter int unsigned I1_PREC = 8,
  parameter bit          I1_SGN  = 1'b1,
  parameter int unsigned I2_PREC = 8,
  parameter bit          I2_SGN  = 1'b1,
  parameter int unsigned O_PREC  = 8,
  parameter bit          O_SGN   = 1'b1
) (
  input  logic [I1_PREC-1:0] in1,
  input  logic [I2_PREC-1:0] in2,
  output logic [O_PREC-1:0]  out,
  output logic               ovf
);

  localparam int unsigned MAXI = (I1_PREC > I2_PREC) ? I1_PREC : I2_PREC;
  localparam int unsigned MAXP = (MAXI > O_PREC) ? MAXI : O_PREC;
  localparam int unsigned W    = MAXP + 2;

  localparam logic signed [W-1:0] OMAX = O_SGN ? ((W'(1) << (O_PREC - 1)) - W'(1))
                                               : ((W'(1) << O_PREC) - W'(1));
  localparam logic signed [W-1:0] OMIN = O_SGN ? -(W'(1) << (O_PREC - 1)) : W'(0);

  logic signed [W-1:0] a, b, d;

  assign a = $signed({{(W - I1_PREC){I1_SGN & in1[I1_PREC-1]}}, in1});
  assign b = $signed({{(W - I2_PREC){I2_SGN & in2[I2_PREC-1]}}, in2});
  assign d = a - b;

  // Exact difference at full width, then clamp into the result range.
  always_comb begin
    out = d[O_PREC-1:0];
    ovf = 1'b0;
    if (d > OMAX) begin
      out = OMAX[O_PREC-1:0];
      ovf = 1'b1;
    end else if (d < OMIN) begin
      out = OMIN[O_PREC-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/p_rr_arb.sv
// Round-robin grant: first requester at or after ptr, wrapping, as one-hot plus index.
module p_rr_arb #(
  parameter int unsigned REQ  = 4,
  parameter int unsigned ID_W = $clog2(REQ)
) (
  input  logic [REQ-1:0]  req,
  input  logic [ID_W-1:0] ptr,
  output logic [REQ-1:0]  gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned    pos;
  logic [REQ-1:0] req_sh;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = |req;
    pos    = 0;
    req_sh = '0;
    // Walk from the farthest offset back so the nearest requester overwrites last.
    for (int off = REQ - 1; off >= 0; off--) begin
      pos    = (32'(ptr) + 32'(off)) % REQ;
      req_sh = req >> pos;
      if (req_sh[0]) begin
        gnt = REQ'(1) << pos;
        idx = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/p_sub_arb.sv
// Round-robin share of one saturating subtractor with a one-deep tagged response register.
module p_sub_arb
  import p_sub_arb_pkg::*;
#(
  parameter int unsigned REQ     = 4,
  parameter dconf_t      I1_CONF = DEF_DCONF_INT,
  parameter dconf_t      I2_CONF = DEF_DCONF_INT,
  parameter dconf_t      O_CONF  = DEF_DCONF_INT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_,
  p_sub_arb_if.slave       bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             busy
);

  localparam int unsigned I1_PREC = I1_CONF.prec;
  localparam int unsigned I2_PREC = I2_CONF.prec;
  localparam int unsigned O_PREC  = O_CONF.prec;
  localparam int unsigned ID_W    = $clog2(REQ);

  arb_state_e        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   g_idx;
  logic [REQ-1:0]    g_onehot;
  logic              any_valid, can_acc, accept;
  logic [I1_PREC-1:0] op1;
  logic [I2_PREC-1:0] op2;
  logic [O_PREC-1:0] sub_out;
  logic              sub_ovf;

  p_rr_arb #(
    .REQ (REQ),
    .ID_W(ID_W)
  ) u_arb (
    .req(bus.req_valid),
    .ptr(ptr),
    .gnt(g_onehot),
    .idx(g_idx),
    .any(any_valid)
  );

  // Grant depends only on req_valid, state and rsp_ready; operands never feed back.
  assign can_acc       = (state == StEmpty) || bus.rsp_ready;
  assign accept        = can_acc && any_valid;
  assign bus.req_ready = accept ? g_onehot : '0;
  assign busy          = bus.rsp_valid;

  assign op1 = I1_PREC'(bus.req_in1 >> (32'(g_idx) * I1_PREC));
  assign op2 = I2_PREC'(bus.req_in2 >> (32'(g_idx) * I2_PREC));

  p_int_sub #(
    .I1_PREC(I1_PREC),
    .I1_SGN (I1_CONF.sgn),
    .I2_PREC(I2_PREC),
    .I2_SGN (I2_CONF.sgn),
    .O_PREC (O_PREC),
    .O_SGN  (O_CONF.sgn)
  ) u_sub (
    .in1(op1),
    .in2(op2),
    .out(sub_out),
    .ovf(sub_ovf)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state         <= StEmpty;
      ptr           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_out   <= '0;
      bus.rsp_ovf   <= 1'b0;
    end else if (accept) begin
      state         <= StFull;
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= g_idx;
      bus.rsp_out   <= sub_out;
      bus.rsp_ovf   <= sub_ovf;
      ptr           <= (g_idx == ID_W'(REQ - 1)) ? '0 : g_idx + 1'b1;
    end else if (bus.rsp_ready) begin
      state         <= StEmpty;
      bus.rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (accept && sub_ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_p_sub_arb.sv
// Bench for p_sub_arb: per-cycle behavioural model on a signed instance plus directed checks.
module tb_p_sub_arb;
  import p_sub_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        cnt_clr2 = 1'b0;
  logic [15:0] ovf_cnt;
  logic [1:0]  ovf_cnt2;
  logic        busy, busy2;

  p_sub_arb_if #(.REQ(4), .I1_PREC(8), .I2_PREC(8), .O_PREC(8)) bus ();
  p_sub_arb_if #(.REQ(4), .I1_PREC(8), .I2_PREC(8), .O_PREC(8)) bus2 ();

  p_sub_arb #(
    .REQ(4), .I1_CONF(DEF_DCONF_INT), .I2_CONF(DEF_DCONF_INT), .O_CONF(DEF_DCONF_INT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_(reset_), .bus(bus), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  p_sub_arb #(
    .REQ(4), .I1_CONF(DEF_DCONF_UINT), .I2_CONF(DEF_DCONF_UINT), .O_CONF(DEF_DCONF_UINT),
    .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset_(reset_), .bus(bus2), .cnt_clr(cnt_clr2), .ovf_cnt(ovf_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_ss(input int a, input int b, output bit o);
    int d;
    d = a - b;
    o = 1'b0;
    if (d > 127) begin
      d = 127;
      o = 1'b1;
    end else if (d < -128) begin
      d = -128;
      o = 1'b1;
    end
    return d;
  endfunction

  // Model state for the signed instance: held response, rotation pointer, overflow tally.
  bit m_full = 1'b0;
  int m_ptr = 0;
  int m_id = 0;
  int m_out = 0;
  bit m_ovf = 1'b0;
  int m_cnt = 0;

  always @(negedge clk) begin : model_blk
    int         g, p, r;
    bit         acc, o;
    logic [3:0] exp_rdy;
    logic [7:0] a8, b8;
    if (!reset_) begin
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        p = (m_ptr + k) % 4;
        if (g < 0 && bus.req_valid[p]) g = p;
      end
      acc     = (!m_full || bus.rsp_ready) && (g >= 0);
      exp_rdy = acc ? 4'(1 << g) : 4'b0;
      chk("model_req_ready", bus.req_ready, exp_rdy);
      chk("model_rsp_valid", bus.rsp_valid, m_full);
      chk("model_busy", busy, m_full);
      chk("model_ovf_cnt", ovf_cnt, m_cnt);
      if (m_full) begin
        chk("model_rsp_id", bus.rsp_id, m_id);
        chk("model_rsp_out", bus.rsp_out, m_out);
        chk("model_rsp_ovf", bus.rsp_ovf, m_ovf);
      end
      if (acc) begin
        a8     = bus.req_in1[8*g +: 8];
        b8     = bus.req_in2[8*g +: 8];
        r      = sat_ss(int'($signed(a8)), int'($signed(b8)), o);
        m_full = 1'b1;
        m_id   = g;
        m_out  = r & 255;
        m_ovf  = o;
        m_ptr  = (g + 1) % 4;
        if (o && m_cnt < 65535) m_cnt++;
      end else if (bus.rsp_ready) begin
        m_full = 1'b0;
      end
      if (cnt_clr) m_cnt = 0;
    end
  end

  int eo[4] = '{0, 9, 18, 27};

  initial begin
    bus.req_valid  = '0;
    bus.req_in1    = '0;
    bus.req_in2    = '0;
    bus.rsp_ready  = 1'b0;
    bus2.req_valid = '0;
    bus2.req_in1   = '0;
    bus2.req_in2   = '0;
    bus2.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_out", bus.rsp_out, 0);
    chk("reset_ovf_cnt2", ovf_cnt2, 0);
    step();
    reset_         = 1'b1;
    bus.rsp_ready  = 1'b1;
    bus2.rsp_ready = 1'b1;

    // Simple difference from requester 0.
    bus.req_in1[7:0] = 8'd10;
    bus.req_in2[7:0] = 8'd3;
    bus.req_valid    = 4'b0001;
    @(negedge clk);
    chk("t1_req_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 0);
    chk("t1_rsp_out", bus.rsp_out, 7);
    chk("t1_rsp_ovf", bus.rsp_ovf, 0);

    // Negative saturation from requester 1.
    step();
    bus.req_in1[15:8] = 8'h9C;
    bus.req_in2[15:8] = 8'd100;
    bus.req_valid     = 4'b0010;
    @(negedge clk);
    chk("t2_req_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t2_rsp_out", bus.rsp_out, 8'h80);
    chk("t2_rsp_ovf", bus.rsp_ovf, 1);
    chk("t2_ovf_cnt", ovf_cnt, 1);

    // Wrap the pointer through requester 3, then stream all four.
    step();
    bus.req_in1   = {8'd30, 8'd20, 8'd10, 8'd0};
    bus.req_in2   = {8'd3, 8'd2, 8'd1, 8'd0};
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("t3_req_ready_wrap", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("t3_first_id", bus.rsp_id, 3);
    chk("t3_first_out", bus.rsp_out, 27);
    chk("t3_ready0", bus.req_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("t3_seq_valid", bus.rsp_valid, 1);
      chk("t3_seq_id", bus.rsp_id, k % 4);
      chk("t3_seq_out", bus.rsp_out, eo[k % 4]);
    end

    // Backpressure: response for requester 2 held for three cycles.
    step();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_id", bus.rsp_id, 2);
      chk("t4_hold_out", bus.rsp_out, 18);
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_ready", bus.req_ready, 4'b0000);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t4_next_id", bus.rsp_id, 3);
    chk("t4_next_out", bus.rsp_out, 27);

    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_main_clr", ovf_cnt, 0);

    // Unsigned instance: 3 - 5 clamps to 0; 2-bit counter saturates, then clear wins.
    step();
    bus2.req_in1[7:0] = 8'd3;
    bus2.req_in2[7:0] = 8'd5;
    bus2.req_valid    = 4'b0001;
    step();
    @(negedge clk);
    chk("uu_rsp_out", bus2.rsp_out, 0);
    chk("uu_rsp_ovf", bus2.rsp_ovf, 1);
    chk("uu_rsp_id", bus2.rsp_id, 0);
    chk("uu_cnt1", ovf_cnt2, 1);
    repeat (4) step();
    chk("uu_cnt_sat", ovf_cnt2, 3);
    cnt_clr2 = 1'b1;
    step();
    cnt_clr2       = 1'b0;
    bus2.req_valid = '0;
    @(negedge clk);
    chk("uu_clr_wins", ovf_cnt2, 0);
    chk("uu_clr_rsp_ovf", bus2.rsp_ovf, 1);

    // Reset while FULL with the pointer at 3.
    step();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_grant2", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    chk("t6_full_before_rst", bus.rsp_valid, 1);
    reset_ = 1'b0;
    #1;
    chk("t6_rst_async_valid", bus.rsp_valid, 0);
    chk("t6_rst_async_busy", busy, 0);
    @(negedge clk);
    step();
    reset_        = 1'b1;
    bus.req_valid = 4'b0101;
    @(negedge clk);
    chk("t6_post_rst_grant0", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_second_grant2", bus.req_ready, 4'b0100);
    chk("t6_rsp_id0", bus.rsp_id, 0);
    chk("t6_rsp_out0", bus.rsp_out, 0);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
